// File: rtl/i2c_codec_responder_pkg.sv
// Shared types and constants for the codec I2C responder: FSM states,
// the register-reload address and the codec power-on register values.
package codec_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG_HI,
        ST_REG_ACK,
        ST_DATA_LO,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic [6:0] REG_RESET_ADDR = 7'h0F;
    localparam int         NUM_DEFAULTS   = 10;

    // Entry [0] is R0; the concatenation lists R9 first.
    localparam logic [NUM_DEFAULTS-1:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };

endpackage

// File: rtl/i2c_codec_responder_bus_sync.sv
// Brings SCL/SDA into the CLOCK_50 domain and flags SCL edges and START/STOP.
// Events are registered, so they appear 3 cycles after the pin edge.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
    logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
    logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic start_q, start_d, stop_q, stop_d;

    always_comb begin
        scl_s1_d   = scl_in;
        scl_s2_d   = scl_s1_q;
        scl_prev_d = scl_s2_q;
        sda_s1_d   = sda_in;
        sda_s2_d   = sda_s1_q;
        sda_prev_d = sda_s2_q;
        scl_rise_d = scl_s2_q & ~scl_prev_q;
        scl_fall_d = ~scl_s2_q & scl_prev_q;
        start_d    = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
        stop_d     = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    end

    // Chain resets to the idle bus level so no false event follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            scl_prev_q <= scl_prev_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            sda_prev_q <= sda_prev_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // sda_prev_q is the SDA level that lines up with the registered events.
    assign sda      = sda_prev_q;
    assign scl_rise = scl_rise_q;
    assign scl_fall = scl_fall_q;
    assign start    = start_q;
    assign stop     = stop_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target modelling the WM8731 control port.
// state       | meaning
// ST_IDLE     | bus free, waiting for START
// ST_ADDR     | shifting {addr[6:0], R/W}
// ST_ADDR_ACK | driving ACK for our address
// ST_REG_HI   | shifting {reg[6:0], d[8]}
// ST_REG_ACK  | driving ACK for the register byte
// ST_DATA_LO  | shifting d[7:0]
// ST_DATA_ACK | driving ACK; its closing SCL fall commits the write
// ST_IGNORE   | NACKing everything until START or STOP
module i2c_codec_responder
    import codec_i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A,
    parameter int         NUM_REGS    = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync u_sync (
        .clk      (CLOCK_50),
        .reset    (reset),
        .scl_in   (I2C_SCLK),
        .sda_in   (I2C_SDAT),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e                    state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      byte_done_q, byte_done_d;
    logic [7:0]                shreg_q, shreg_d;
    logic [6:0]                reg_addr_q, reg_addr_d;
    logic                      data_hi_q, data_hi_d;
    logic                      sda_oe_q, sda_oe_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [6:0]                wr_addr_q, wr_addr_d;
    logic [8:0]                wr_data_q, wr_data_d;
    logic                      commit;
    logic [NUM_REGS-1:0][8:0]  regs_q, regs_d, reg_init;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_init
        if (g < NUM_DEFAULTS) begin : g_dflt
            assign reg_init[g] = REG_DEFAULTS[g];
        end else begin : g_zero
            assign reg_init[g] = 9'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        shreg_d     = shreg_q;
        reg_addr_d  = reg_addr_q;
        data_hi_d   = data_hi_q;
        sda_oe_d    = sda_oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        commit      = 1'b0;
        if (start) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd7;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (stop) begin
            state_d     = ST_IDLE;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG_HI, ST_DATA_LO: begin
                    if (scl_rise && !byte_done_q) begin
                        shreg_d = {shreg_q[6:0], sda};
                        if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
                        else                   bit_cnt_d   = bit_cnt_q - 3'd1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd7;
                        sda_oe_d    = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shreg_q == {DEVICE_ADDR, 1'b0}) begin
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d  = ST_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == ST_REG_HI) begin
                            reg_addr_d = shreg_q[7:1];
                            data_hi_d  = shreg_q[0];
                            state_d    = ST_REG_ACK;
                        end else begin
                            state_d = ST_DATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_REG_HI;
                end
                ST_REG_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_DATA_LO;
                end
                ST_DATA_ACK: if (scl_fall) begin
                    sda_oe_d   = 1'b0;
                    state_d    = ST_IGNORE;
                    commit     = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = reg_addr_q;
                    wr_data_d  = {data_hi_q, shreg_q};
                end
                default: ;
            endcase
        end
    end

    // Unmapped register addresses are acknowledged and reported but not stored.
    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            if (reg_addr_q == REG_RESET_ADDR) regs_d = reg_init;
            else if (int'(reg_addr_q) < NUM_REGS) regs_d[reg_addr_q[3:0]] = wr_data_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            byte_done_q <= 1'b0;
            shreg_q     <= 8'd0;
            reg_addr_q  <= 7'd0;
            data_hi_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            regs_q      <= reg_init;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            shreg_q     <= shreg_d;
            reg_addr_q  <= reg_addr_d;
            data_hi_q   <= data_hi_d;
            sda_oe_q    <= sda_oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    // Gating with reset frees the bus in the same cycle reset is raised.
    assign I2C_SDAT = (sda_oe_q && !reset) ? 1'b0 : 1'bz;
    assign rd_data  = (int'(rd_addr) < NUM_REGS) ? regs_q[rd_addr] : 9'd0;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master, register model and a
// commit scoreboard checked against every wr_valid pulse.
module tb_i2c_codec_responder;

    localparam int HALF = 12;

    logic       clk = 1'b0;
    logic       reset, scl, sda_m;
    wire        sda_bus;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;

    always #10 clk = ~clk;

    assign sda_bus = sda_m ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_codec_responder dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    typedef struct {
        logic [6:0] a;
        logic [8:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [2:0] acks;
        logic       commit;
        logic [3:0] chk_a;
        logic [8:0] chk_d;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];
    logic [8:0] model_regs [16];
    vec_t       vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [8:0] dflt(input int i);
        case (i)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4, 7:    return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            default: return 9'h000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = dflt(i);
    endtask

    task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        if (a == 7'h0F) model_reset();
        else if (a < 7'd10) model_regs[a[3:0]] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("rd%0d_%s", i, tag), 32'(rd_data), 32'(model_regs[i]));
        end
    endtask

    always @(negedge clk) begin
        if (wr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual addr=%0h data=%0h required=no commit", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // START and repeated START: SDA falls while SCL is high.
    task automatic i2c_start();
        sda_m = 1'b1;
        cyc(HALF);
        scl = 1'b1;
        cyc(HALF);
        sda_m = 1'b0;
        cyc(HALF);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(2);
        sda_m = 1'b0;
        cyc(HALF);
        scl = 1'b1;
        cyc(HALF);
        sda_m = 1'b1;
        cyc(HALF);
    endtask

    task automatic clock_bit(input logic b, output logic sampled);
        cyc(2);
        sda_m = b;
        cyc(HALF - 2);
        scl = 1'b1;
        cyc(HALF / 2);
        @(negedge clk);
        sampled = sda_bus;
        cyc(HALF / 2);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic do_write(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            output logic [2:0] acks);
        logic a0, a1, a2;
        i2c_start();
        send_byte(b0, a0);
        send_byte(b1, a1);
        send_byte(b2, a2);
        i2c_stop();
        acks = {a0, a1, a2};
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] acks;
        logic       a, s;

        vecs[0] = '{8'h34, 8'h08, 8'h12, 3'b111, 1'b1, 4'd4,  9'h012};
        vecs[1] = '{8'h36, 8'h08, 8'h55, 3'b000, 1'b0, 4'd4,  9'h012};
        vecs[2] = '{8'h35, 8'h08, 8'h55, 3'b000, 1'b0, 4'd4,  9'h012};
        vecs[3] = '{8'h34, 8'h0C, 8'h00, 3'b111, 1'b1, 4'd6,  9'h000};
        vecs[4] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1'b1, 4'd6,  9'h09F};
        vecs[5] = '{8'h34, 8'h14, 8'h55, 3'b111, 1'b1, 4'd10, 9'h000};
        vecs[6] = '{8'h34, 8'h05, 8'hFF, 3'b111, 1'b1, 4'd2,  9'h1FF};
        vecs[7] = '{8'h34, 8'h13, 8'h01, 3'b111, 1'b1, 4'd9,  9'h101};
        vecs[8] = '{8'h34, 8'h1F, 8'hAA, 3'b111, 1'b1, 4'd2,  9'h079};
        vecs[9] = '{8'h34, 8'h00, 8'h80, 3'b111, 1'b1, 4'd0,  9'h080};

        reset   = 1'b1;
        scl     = 1'b1;
        sda_m   = 1'b1;
        rd_addr = 4'd0;
        model_reset();
        cyc(5);
        @(negedge clk);
        reset = 1'b0;
        cyc(5);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_sda", 32'(sda_bus), 1);
        check_regs("reset");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].commit) model_commit(vecs[i].b1[7:1], {vecs[i].b1[0], vecs[i].b2});
            do_write(vecs[i].b0, vecs[i].b1, vecs[i].b2, acks);
            check($sformatf("acks_v%0d", i), 32'(acks), 32'(vecs[i].acks));
            cyc(4);
            rd_addr = vecs[i].chk_a;
            #1;
            check($sformatf("rd_v%0d", i), 32'(rd_data), 32'(vecs[i].chk_d));
            check_regs($sformatf("v%0d", i));
        end

        // Unmapped register write followed by a fourth byte that must be NACKed.
        model_commit(7'h0A, 9'h055);
        i2c_start();
        cyc(6);
        check("busy_start", 32'(busy), 1);
        send_byte(8'h34, a);
        check("ack4_b0", 32'(a), 1);
        send_byte(8'h14, a);
        check("ack4_b1", 32'(a), 1);
        send_byte(8'h55, a);
        check("ack4_b2", 32'(a), 1);
        send_byte(8'h77, a);
        check("nack_b3", 32'(a), 0);
        i2c_stop();
        check("busy_stop", 32'(busy), 0);
        check_regs("fourth");

        // STOP after the register byte: no commit.
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h04, a);
        check("stop_b1_ack", 32'(a), 1);
        i2c_stop();
        check_regs("stop");

        // Repeated START after the register byte, then a full write to reg 2.
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h04, a);
        model_commit(7'h02, 9'h1FF);
        i2c_start();
        send_byte(8'h34, a);
        check("rs_b0_ack", 32'(a), 1);
        send_byte(8'h05, a);
        send_byte(8'hFF, a);
        check("rs_b2_ack", 32'(a), 1);
        i2c_stop();
        check_regs("rstart");

        // Reset raised inside the register-byte ACK window.
        i2c_start();
        send_byte(8'h34, a);
        for (int i = 7; i >= 0; i--) clock_bit(i[0] ? 1'b0 : ((i == 3 || i == 2) ? 1'b1 : 1'b0), s);
        sda_m = 1'b1;
        cyc(6);
        @(negedge clk);
        check("mid_ack_low", 32'(sda_bus), 0);
        reset = 1'b1;
        #1;
        check("mid_rst_sda", 32'(sda_bus), 1);
        cyc(3);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_wr_addr", 32'(wr_addr), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check_regs("midrst");
        scl = 1'b1;
        cyc(HALF);
        scl = 1'b0;
        i2c_stop();
        cyc(20);
        check("mid_rst_sda_idle", 32'(sda_bus), 1);
        check_regs("final");
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
